// File: rtl/ahb_master_burst_ctrl.sv
// AHB master burst sequencer: takes one burst command, arbitrates for the bus and
// drives pipelined address/data phases, handling grant loss, wait states and ERROR.
module ahb_master_burst_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_burst,
  input  logic [2:0]        cmd_size,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              done_err,
  output logic              Hbusreq,
  input  logic              Hgrant,
  input  logic              Hready,
  input  logic [1:0]        Hresp,
  input  logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Htrans,
  output logic [ADDR_W-1:0] Haddr,
  output logic [2:0]        Hburst,
  output logic [2:0]        Hsize,
  output logic              Hwrite,
  output logic [DATA_W-1:0] Hwdata
);

  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] BURST_INCR = 3'b001;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_LAST, S_GAP} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] mask_reg;
  logic              wrap_reg;
  logic [2:0]        burst_reg;
  logic [2:0]        size_reg;
  logic              write_reg;
  logic [4:0]        addr_left_reg;
  logic [4:0]        data_left_reg;
  logic              first_reg;
  logic              dp_pending_reg;

  function automatic logic [4:0] beat_count(input logic [2:0] burst, input logic [4:0] len);
    case (burst)
      3'b000:         beat_count = 5'd1;
      3'b001:         beat_count = (len == 5'd0) ? 5'd1 : len;
      3'b010, 3'b011: beat_count = 5'd4;
      3'b100, 3'b101: beat_count = 5'd8;
      default:        beat_count = 5'd16;
    endcase
  endfunction

  logic [4:0]        cmd_beats;
  logic              cmd_wrap;
  logic [ADDR_W-1:0] cmd_mask;
  logic              accept;

  assign cmd_beats = beat_count(cmd_burst, cmd_len);
  assign cmd_wrap  = (cmd_burst[0] == 1'b0) && (cmd_burst != 3'b000);
  assign cmd_mask  = ({{(ADDR_W-5){1'b0}}, cmd_beats} << cmd_size) - ADDR_ONE;
  assign accept    = (state_reg == S_IDLE) && cmd_valid;

  // An ERROR response on the pending data phase suppresses everything on the address side.
  logic resp_err, data_fire, err_end, addr_fire;
  assign resp_err  = dp_pending_reg && (Hresp == RESP_ERROR);
  assign data_fire = dp_pending_reg && Hready && !resp_err;
  assign err_end   = dp_pending_reg && Hready && resp_err;
  assign addr_fire = (state_reg == S_ADDR) && Hready && !resp_err;

  logic [ADDR_W-1:0] addr_inc, addr_adv;
  assign addr_inc = addr_reg + (ADDR_ONE << size_reg);

  // Wrapping bursts keep every address bit above the wrap boundary.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr_adv
      assign addr_adv[gi] = (wrap_reg && !mask_reg[gi]) ? addr_reg[gi] : addr_inc[gi];
    end
  endgenerate

  assign wdata_ack   = data_fire && write_reg;
  assign rdata_valid = data_fire && !write_reg;
  assign rdata       = rdata_valid ? Hrdata : '0;
  assign done        = (data_fire && (data_left_reg == 5'd1)) || err_end;
  assign done_err    = err_end;
  assign Haddr       = addr_reg;
  assign Hburst      = burst_reg;
  assign Hsize       = size_reg;
  assign Hwrite      = write_reg;
  assign Hwdata      = (dp_pending_reg && write_reg) ? wdata : '0;

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    Hbusreq    = 1'b0;
    Htrans     = TR_IDLE;
    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = S_REQ;
      end
      S_REQ: begin
        Hbusreq = 1'b1;
        if (Hgrant && Hready) state_next = S_ADDR;
      end
      S_ADDR: begin
        Hbusreq = (addr_left_reg > 5'd1) && !resp_err;
        if (!resp_err) Htrans = first_reg ? TR_NONSEQ : TR_SEQ;
        if (addr_fire) begin
          if (addr_left_reg == 5'd1) state_next = S_LAST;
          else if (!Hgrant)          state_next = S_GAP;
        end
      end
      S_GAP: begin
        Hbusreq = !resp_err;
        if (data_fire) state_next = S_REQ;
      end
      default: ;
    endcase
    if (done) state_next = S_IDLE;
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      mask_reg       <= '0;
      wrap_reg       <= 1'b0;
      burst_reg      <= 3'b000;
      size_reg       <= 3'b000;
      write_reg      <= 1'b0;
      addr_left_reg  <= 5'd0;
      data_left_reg  <= 5'd0;
      first_reg      <= 1'b0;
      dp_pending_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg       <= cmd_addr;
        mask_reg       <= cmd_mask;
        wrap_reg       <= cmd_wrap;
        burst_reg      <= cmd_burst;
        size_reg       <= cmd_size;
        write_reg      <= cmd_write;
        addr_left_reg  <= cmd_beats;
        data_left_reg  <= cmd_beats;
        first_reg      <= 1'b1;
        dp_pending_reg <= 1'b0;
      end else begin
        if (addr_fire) begin
          addr_reg      <= addr_adv;
          addr_left_reg <= addr_left_reg - 5'd1;
          first_reg     <= 1'b0;
          // Lost the bus mid-burst: the remainder restarts as an undefined-length INCR.
          if (!Hgrant && (addr_left_reg != 5'd1)) begin
            first_reg <= 1'b1;
            burst_reg <= BURST_INCR;
          end
        end
        if (data_fire) data_left_reg <= data_left_reg - 5'd1;
        if (addr_fire)                 dp_pending_reg <= 1'b1;
        else if (data_fire || err_end) dp_pending_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_burst_ctrl.sv
// Directed bench for ahb_master_burst_ctrl: per-cycle bus patterns drive each command
// and the recorded trace is compared against hand-derived expectations.
module tb_ahb_master_burst_ctrl;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_burst;
  logic [2:0]  cmd_size;
  logic [4:0]  cmd_len;
  logic [31:0] wdata;
  logic        wdata_ack;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        done_err;
  logic        Hbusreq;
  logic        Hgrant;
  logic        Hready;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [2:0]  Hburst;
  logic [2:0]  Hsize;
  logic        Hwrite;
  logic [31:0] Hwdata;

  int checks   = 0;
  int failures = 0;

  always #5 Hclk = ~Hclk;

  ahb_master_burst_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
    .done(done), .done_err(done_err),
    .Hbusreq(Hbusreq), .Hgrant(Hgrant), .Hready(Hready), .Hresp(Hresp), .Hrdata(Hrdata),
    .Htrans(Htrans), .Haddr(Haddr), .Hburst(Hburst), .Hsize(Hsize), .Hwrite(Hwrite),
    .Hwdata(Hwdata)
  );

  logic        gnt_pat  [64];
  logic        rdy_pat  [64];
  logic [1:0]  resp_pat [64];

  logic [1:0]  tr_log    [64];
  logic [31:0] addr_log  [64];
  logic [31:0] rd_log    [64];
  logic [31:0] hw_log    [64];
  logic [2:0]  burst_log [64];
  logic        busreq_log[64];
  logic        rv_log    [64];
  logic        wa_log    [64];
  logic        done_log  [64];
  logic        derr_log  [64];
  logic        cr_log    [64];
  logic        hwrite_log[64];

  task automatic set_default();
    for (int i = 0; i < 64; i++) begin
      gnt_pat[i]  = 1'b1;
      rdy_pat[i]  = 1'b1;
      resp_pat[i] = 2'b00;
    end
  endtask

  // Starts just after a rising edge with the DUT idle; cycle 0 offers the command.
  task automatic run_cmd(input logic [31:0] a, input logic w, input logic [2:0] b,
                         input logic [2:0] s, input logic [4:0] l, input int n,
                         input int vlo, input int vhi);
    for (int c = 0; c < n; c++) begin
      cmd_valid = (c == 0) || (c >= vlo && c <= vhi);
      cmd_addr  = a;
      cmd_write = w;
      cmd_burst = b;
      cmd_size  = s;
      cmd_len   = l;
      Hgrant    = gnt_pat[c];
      Hready    = rdy_pat[c];
      Hresp     = resp_pat[c];
      Hrdata    = 32'hA000_0000 + 32'(c);
      wdata     = 32'h5000_0000 + 32'(c);
      #1;
      tr_log[c]     = Htrans;
      addr_log[c]   = Haddr;
      rd_log[c]     = rdata;
      hw_log[c]     = Hwdata;
      burst_log[c]  = Hburst;
      busreq_log[c] = Hbusreq;
      rv_log[c]     = rdata_valid;
      wa_log[c]     = wdata_ack;
      done_log[c]   = done;
      derr_log[c]   = done_err;
      cr_log[c]     = cmd_ready;
      hwrite_log[c] = Hwrite;
      @(posedge Hclk);
      #1;
    end
    cmd_valid = 1'b0;
    $display("cmd addr=%08h write=%0d burst=%03b size=%0d len=%0d cycles=%0d", a, w, b, s, l, n);
  endtask

  task automatic test_reset();
    Hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_write = 1'b0;
    cmd_burst = 3'b0; cmd_size = 3'b0; cmd_len = 5'd0; wdata = 32'h0;
    Hgrant = 1'b0; Hready = 1'b1; Hresp = 2'b00; Hrdata = 32'h0;
    repeat (2) @(posedge Hclk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
    checks++; if (Htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%0b exp=00", Htrans); end
    checks++; if (Hbusreq !== 1'b0) begin failures++; $display("FAIL reset_hbusreq got=%0b exp=0", Hbusreq); end
    checks++; if (Haddr !== 32'h0) begin failures++; $display("FAIL reset_haddr got=%08h exp=0", Haddr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    Hreset = 1'b0;
    @(posedge Hclk);
    #1;
    $display("reset released");
  endtask

  task automatic test_single_write();
    set_default();
    run_cmd(32'h100, 1'b1, 3'b000, 3'd2, 5'd0, 5, -1, -1);
    checks++; if (cr_log[0] !== 1'b1) begin failures++; $display("FAIL single_ready c0 got=%0b exp=1", cr_log[0]); end
    checks++; if (busreq_log[1] !== 1'b1 || tr_log[1] !== 2'b00) begin failures++; $display("FAIL single_req c1 busreq=%0b trans=%0b exp busreq=1 trans=00", busreq_log[1], tr_log[1]); end
    checks++; if (tr_log[2] !== 2'b10 || addr_log[2] !== 32'h100) begin failures++; $display("FAIL single_addr c2 trans=%0b addr=%08h exp 10/00000100", tr_log[2], addr_log[2]); end
    checks++; if (hwrite_log[2] !== 1'b1 || busreq_log[2] !== 1'b0) begin failures++; $display("FAIL single_ctrl c2 hwrite=%0b busreq=%0b exp 1/0", hwrite_log[2], busreq_log[2]); end
    checks++; if (wa_log[3] !== 1'b1 || done_log[3] !== 1'b1) begin failures++; $display("FAIL single_ack c3 ack=%0b done=%0b exp 1/1", wa_log[3], done_log[3]); end
    checks++; if (hw_log[3] !== 32'h5000_0003) begin failures++; $display("FAIL single_hwdata c3 got=%08h exp=50000003", hw_log[3]); end
    checks++; if (busreq_log[3] !== 1'b0 || tr_log[3] !== 2'b00) begin failures++; $display("FAIL single_dphase c3 busreq=%0b trans=%0b exp 0/00", busreq_log[3], tr_log[3]); end
    checks++; if (wa_log[2] !== 1'b0 || done_log[4] !== 1'b0 || cr_log[4] !== 1'b1) begin failures++; $display("FAIL single_end ack2=%0b done4=%0b ready4=%0b exp 0/0/1", wa_log[2], done_log[4], cr_log[4]); end
  endtask

  task automatic test_incr4_wait();
    logic [1:0]  exp_tr [9];
    logic [31:0] exp_a  [6];
    set_default();
    rdy_pat[4] = 1'b0;
    rdy_pat[5] = 1'b0;
    run_cmd(32'h20, 1'b0, 3'b011, 3'd2, 5'd0, 10, -1, -1);
    exp_tr = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    exp_a  = '{32'h20, 32'h24, 32'h28, 32'h28, 32'h28, 32'h2C};
    for (int c = 0; c < 9; c++) begin
      checks++; if (tr_log[c] !== exp_tr[c]) begin failures++; $display("FAIL incr4_htrans c%0d got=%0b exp=%0b", c, tr_log[c], exp_tr[c]); end
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (addr_log[2+i] !== exp_a[i]) begin failures++; $display("FAIL incr4_haddr c%0d got=%08h exp=%08h", 2+i, addr_log[2+i], exp_a[i]); end
    end
    for (int c = 0; c < 10; c++) begin
      logic exp_v;
      exp_v = (c == 3) || (c == 6) || (c == 7) || (c == 8);
      checks++; if (rv_log[c] !== exp_v) begin failures++; $display("FAIL incr4_rvalid c%0d got=%0b exp=%0b", c, rv_log[c], exp_v); end
      if (exp_v) begin
        checks++; if (rd_log[c] !== 32'hA000_0000 + 32'(c)) begin failures++; $display("FAIL incr4_rdata c%0d got=%08h exp=%08h", c, rd_log[c], 32'hA000_0000 + 32'(c)); end
      end
      checks++; if (done_log[c] !== (c == 8)) begin failures++; $display("FAIL incr4_done c%0d got=%0b exp=%0b", c, done_log[c], (c == 8)); end
    end
  endtask

  task automatic test_wrap8();
    logic [31:0] exp_a [8];
    int nv;
    set_default();
    run_cmd(32'h38, 1'b0, 3'b100, 3'd2, 5'd0, 12, -1, -1);
    exp_a = '{32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34};
    for (int i = 0; i < 8; i++) begin
      checks++; if (addr_log[2+i] !== exp_a[i]) begin failures++; $display("FAIL wrap8_haddr c%0d got=%08h exp=%08h", 2+i, addr_log[2+i], exp_a[i]); end
    end
    checks++; if (burst_log[2] !== 3'b100) begin failures++; $display("FAIL wrap8_hburst got=%03b exp=100", burst_log[2]); end
    checks++; if (tr_log[2] !== 2'b10 || tr_log[9] !== 2'b11 || tr_log[10] !== 2'b00) begin failures++; $display("FAIL wrap8_htrans c2=%0b c9=%0b c10=%0b exp 10/11/00", tr_log[2], tr_log[9], tr_log[10]); end
    nv = 0;
    for (int c = 0; c < 12; c++) if (rv_log[c]) nv++;
    checks++; if (nv != 8) begin failures++; $display("FAIL wrap8_rvalid_count got=%0d exp=8", nv); end
    checks++; if (done_log[10] !== 1'b1 || done_log[9] !== 1'b0) begin failures++; $display("FAIL wrap8_done c9=%0b c10=%0b exp 0/1", done_log[9], done_log[10]); end
  endtask

  task automatic test_incr16_grant_loss();
    int na, nd;
    set_default();
    gnt_pat[7] = 1'b0;
    gnt_pat[8] = 1'b0;
    run_cmd(32'h0, 1'b1, 3'b111, 3'd2, 5'd0, 22, -1, -1);
    checks++; if (burst_log[2] !== 3'b111 || tr_log[2] !== 2'b10) begin failures++; $display("FAIL incr16_start burst=%03b trans=%0b exp 111/10", burst_log[2], tr_log[2]); end
    checks++; if (tr_log[7] !== 2'b11 || addr_log[7] !== 32'h14) begin failures++; $display("FAIL incr16_beat5 trans=%0b addr=%08h exp 11/00000014", tr_log[7], addr_log[7]); end
    checks++; if (tr_log[8] !== 2'b00 || tr_log[9] !== 2'b00) begin failures++; $display("FAIL incr16_gap c8=%0b c9=%0b exp 00/00", tr_log[8], tr_log[9]); end
    checks++; if (busreq_log[9] !== 1'b1) begin failures++; $display("FAIL incr16_rereq got=%0b exp=1", busreq_log[9]); end
    checks++; if (tr_log[10] !== 2'b10 || addr_log[10] !== 32'h18) begin failures++; $display("FAIL incr16_resume trans=%0b addr=%08h exp 10/00000018", tr_log[10], addr_log[10]); end
    checks++; if (burst_log[10] !== 3'b001) begin failures++; $display("FAIL incr16_resume_burst got=%03b exp=001", burst_log[10]); end
    checks++; if (addr_log[19] !== 32'h3C || busreq_log[19] !== 1'b0) begin failures++; $display("FAIL incr16_last addr=%08h busreq=%0b exp 0000003c/0", addr_log[19], busreq_log[19]); end
    na = 0; nd = 0;
    for (int c = 0; c < 22; c++) begin
      if (wa_log[c]) na++;
      if (done_log[c]) nd++;
    end
    checks++; if (na != 16) begin failures++; $display("FAIL incr16_ack_count got=%0d exp=16", na); end
    checks++; if (nd != 1 || done_log[20] !== 1'b1 || derr_log[20] !== 1'b0) begin failures++; $display("FAIL incr16_done count=%0d c20=%0b err=%0b exp 1/1/0", nd, done_log[20], derr_log[20]); end
  endtask

  task automatic test_error();
    int nv, nd;
    set_default();
    rdy_pat[4]  = 1'b0;
    resp_pat[4] = 2'b01;
    resp_pat[5] = 2'b01;
    run_cmd(32'h40, 1'b0, 3'b011, 3'd2, 5'd0, 7, -1, -1);
    checks++; if (tr_log[3] !== 2'b11) begin failures++; $display("FAIL err_pre_trans got=%0b exp=11", tr_log[3]); end
    checks++; if (tr_log[4] !== 2'b00 || busreq_log[4] !== 1'b0) begin failures++; $display("FAIL err_first trans=%0b busreq=%0b exp 00/0", tr_log[4], busreq_log[4]); end
    checks++; if (done_log[5] !== 1'b1 || derr_log[5] !== 1'b1) begin failures++; $display("FAIL err_second done=%0b done_err=%0b exp 1/1", done_log[5], derr_log[5]); end
    checks++; if (busreq_log[5] !== 1'b0 || tr_log[5] !== 2'b00) begin failures++; $display("FAIL err_second_bus busreq=%0b trans=%0b exp 0/00", busreq_log[5], tr_log[5]); end
    nv = 0; nd = 0;
    for (int c = 0; c < 7; c++) begin
      if (rv_log[c]) nv++;
      if (done_log[c]) nd++;
    end
    checks++; if (nv != 1 || rv_log[3] !== 1'b1) begin failures++; $display("FAIL err_rvalid count=%0d c3=%0b exp 1/1", nv, rv_log[3]); end
    checks++; if (nd != 1 || derr_log[3] !== 1'b0) begin failures++; $display("FAIL err_done_count count=%0d err3=%0b exp 1/0", nd, derr_log[3]); end
    checks++; if (cr_log[6] !== 1'b1) begin failures++; $display("FAIL err_idle ready=%0b exp=1", cr_log[6]); end
  endtask

  task automatic test_incr_len();
    logic [31:0] exp_a [3];
    set_default();
    run_cmd(32'h200, 1'b0, 3'b001, 3'd1, 5'd0, 5, -1, -1);
    checks++; if (tr_log[2] !== 2'b10 || addr_log[2] !== 32'h200 || burst_log[2] !== 3'b001) begin failures++; $display("FAIL len0_addr trans=%0b addr=%08h burst=%03b exp 10/00000200/001", tr_log[2], addr_log[2], burst_log[2]); end
    checks++; if (busreq_log[2] !== 1'b0 || tr_log[3] !== 2'b00) begin failures++; $display("FAIL len0_single busreq=%0b trans3=%0b exp 0/00", busreq_log[2], tr_log[3]); end
    checks++; if (done_log[3] !== 1'b1 || rv_log[3] !== 1'b1) begin failures++; $display("FAIL len0_done done=%0b rvalid=%0b exp 1/1", done_log[3], rv_log[3]); end
    set_default();
    run_cmd(32'h7, 1'b0, 3'b001, 3'd0, 5'd3, 7, -1, -1);
    exp_a = '{32'h7, 32'h8, 32'h9};
    for (int i = 0; i < 3; i++) begin
      checks++; if (addr_log[2+i] !== exp_a[i]) begin failures++; $display("FAIL len3_haddr c%0d got=%08h exp=%08h", 2+i, addr_log[2+i], exp_a[i]); end
    end
    checks++; if (done_log[5] !== 1'b1 || done_log[4] !== 1'b0 || cr_log[6] !== 1'b1) begin failures++; $display("FAIL len3_done c4=%0b c5=%0b ready6=%0b exp 0/1/1", done_log[4], done_log[5], cr_log[6]); end
  endtask

  task automatic test_back_to_back();
    int nd;
    set_default();
    run_cmd(32'h300, 1'b0, 3'b000, 3'd2, 5'd0, 9, 3, 4);
    checks++; if (done_log[3] !== 1'b1 || cr_log[3] !== 1'b0) begin failures++; $display("FAIL b2b_first done=%0b ready=%0b exp 1/0", done_log[3], cr_log[3]); end
    checks++; if (cr_log[4] !== 1'b1) begin failures++; $display("FAIL b2b_ready c4 got=%0b exp=1", cr_log[4]); end
    checks++; if (tr_log[5] !== 2'b00 || busreq_log[5] !== 1'b1) begin failures++; $display("FAIL b2b_req c5 trans=%0b busreq=%0b exp 00/1", tr_log[5], busreq_log[5]); end
    checks++; if (tr_log[6] !== 2'b10 || addr_log[6] !== 32'h300) begin failures++; $display("FAIL b2b_addr c6 trans=%0b addr=%08h exp 10/00000300", tr_log[6], addr_log[6]); end
    checks++; if (done_log[7] !== 1'b1 || rd_log[7] !== 32'hA000_0007) begin failures++; $display("FAIL b2b_second done=%0b rdata=%08h exp 1/a0000007", done_log[7], rd_log[7]); end
    nd = 0;
    for (int c = 0; c < 9; c++) if (done_log[c]) nd++;
    checks++; if (nd != 2 || cr_log[8] !== 1'b1) begin failures++; $display("FAIL b2b_done_count count=%0d ready8=%0b exp 2/1", nd, cr_log[8]); end
  endtask

  task automatic test_reset_mid_burst();
    int nd;
    set_default();
    run_cmd(32'h80, 1'b1, 3'b101, 3'd2, 5'd0, 5, -1, -1);
    Hgrant = 1'b1; Hready = 1'b1; Hresp = 2'b00;
    Hreset = 1'b1;
    #1;
    checks++; if (Htrans !== 2'b11 || Haddr !== 32'h8C) begin failures++; $display("FAIL rst_mid_pre trans=%0b addr=%08h exp 11/0000008c", Htrans, Haddr); end
    @(posedge Hclk);
    #1;
    Hreset = 1'b0;
    #1;
    checks++; if (Htrans !== 2'b00 || Hbusreq !== 1'b0) begin failures++; $display("FAIL rst_mid_bus trans=%0b busreq=%0b exp 00/0", Htrans, Hbusreq); end
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_state ready=%0b done=%0b exp 1/0", cmd_ready, done); end
    checks++; if (Haddr !== 32'h0 || wdata_ack !== 1'b0 || Hwdata !== 32'h0) begin failures++; $display("FAIL rst_mid_outs addr=%08h ack=%0b hwdata=%08h exp 0/0/0", Haddr, wdata_ack, Hwdata); end
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge Hclk);
      #1;
      if (done || Htrans != 2'b00) nd++;
    end
    checks++; if (nd != 0) begin failures++; $display("FAIL rst_mid_quiet active_cycles=%0d exp=0", nd); end
    $display("reset mid-burst applied");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_incr4_wait();
    test_wrap8();
    test_incr16_grant_loss();
    test_error();
    test_incr_len();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
